// File: rtl/disp_pkg.sv
// Shared definitions for the display arbiter: FSM state encoding and display word width.
// Ports: none (package only).
// Used by display_arbiter and rr_pick through import disp_pkg::*.
package disp_pkg;

    localparam int DISP_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from i_ptr, wrapping at N_REQ.
// Ports: i_req (request vector), i_ptr (search start index),
//        o_onehot (winner, all-zero if no request), o_idx (winner index, 0 if no request).
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [PW-1:0]    o_idx
);

    logic          w_found;
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        w_cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // One extra bit so ptr+k cannot overflow before the wrap subtraction.
            w_sum = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(N_REQ)) begin
                w_sum = w_sum - (PW+1)'(N_REQ);
            end
            w_cand = w_sum[PW-1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_onehot[w_cand] = 1'b1;
                o_idx            = w_cand;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the seven-segment scan driver's data word; grants one producer,
// registers its word onto dato and keeps ownership for at least HOLD_CYCLES cycles.
// Ports: clk, rst (async, active-high), req/dato_in (producer side), ack/grant/dato/busy (outputs).
module display_arbiter
    import disp_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [DISP_W*N_REQ-1:0] dato_in,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        grant,
    output logic [DISP_W-1:0]       dato,
    output logic                    busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    state_e            r_state, w_nxt_state;
    logic [PW-1:0]     r_ptr, w_nxt_ptr;
    logic [PW-1:0]     r_owner, w_nxt_owner;
    logic [CW-1:0]     r_cnt, w_nxt_cnt;
    logic [N_REQ-1:0]  r_ack, w_nxt_ack;
    logic [N_REQ-1:0]  r_grant, w_nxt_grant;
    logic [DISP_W-1:0] r_dato, w_nxt_dato;

    logic [N_REQ-1:0]  w_win_oh;
    logic [PW-1:0]     w_win_idx;
    logic [DISP_W-1:0] w_words [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign w_words[g] = dato_in[g*DISP_W +: DISP_W];
    end

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_owner = r_owner;
        w_nxt_cnt   = r_cnt;
        w_nxt_grant = r_grant;
        w_nxt_dato  = r_dato;
        w_nxt_ack   = '0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_nxt_dato  = w_words[w_win_idx];
                    w_nxt_grant = w_win_oh;
                    w_nxt_ack   = w_win_oh;
                    w_nxt_owner = w_win_idx;
                    w_nxt_ptr   = (w_win_idx == PW'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;
                    w_nxt_cnt   = RELOAD;
                    w_nxt_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The owner's req is ignored during its ack cycle so one request
                // level cannot be captured on two consecutive edges.
                if (req[r_owner] && (r_ack == '0)) begin
                    w_nxt_dato = w_words[r_owner];
                    w_nxt_ack  = r_grant;
                    w_nxt_cnt  = RELOAD;
                end else if (r_cnt != '0) begin
                    w_nxt_cnt = r_cnt - 1'b1;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_ack   <= '0;
            r_grant <= '0;
            r_dato  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_owner <= w_nxt_owner;
            r_cnt   <= w_nxt_cnt;
            r_ack   <= w_nxt_ack;
            r_grant <= w_nxt_grant;
            r_dato  <= w_nxt_dato;
        end
    end

    assign ack   = r_ack;
    assign grant = r_grant;
    assign dato  = r_dato;
    assign busy  = (r_state == ST_HOLD);

endmodule
